// File: rtl/mac_sequencer_if.sv
// Operand-entry and result bus between the switch/key front end and mac_sequencer.
// The master drives operands and clear; the slave (sequencer) drives status and result.
interface mac_sequencer_if #(
    parameter int WIDTH = 8
) ();
    logic                 clear;
    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic                 in_ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 overflow;

    modport master (
        output clear, in_valid, in_data,
        input  in_ready, busy, done, result, overflow
    );

    modport slave (
        input  clear, in_valid, in_data,
        output in_ready, busy, done, result, overflow
    );
endinterface

// File: rtl/mac_sequencer.sv
// Sum-of-products sequencer: one shift-add multiplier time-shared over NPAIRS operand pairs.
// Optional build macro MAC_SEQUENCER_SATURATE_EN clamps the result to all ones on carry-out.
module mac_sequencer #(
    parameter int WIDTH  = 8,
    parameter int NPAIRS = 2
) (
    input  logic            clk,
    input  logic            reset,
    mac_sequencer_if.slave  bus
);
    localparam int RW = 2 * WIDTH;
    localparam int PW = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam int CW = PW + 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {LOAD, MUL, ACC, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      count;
    logic [PW-1:0]      pair;
    logic [BW-1:0]      bitcnt;
    logic [RW-1:0]      product;
    logic [RW-1:0]      acc;
    logic               carry;
    logic [WIDTH-1:0]   xs [NPAIRS];
    logic [WIDTH-1:0]   ys [NPAIRS];

    logic [WIDTH-1:0]   xop;
    logic [WIDTH-1:0]   yop;
    logic [RW-1:0]      addend;
    logic [RW:0]        acc_sum;

    assign xop     = xs[pair];
    assign yop     = ys[pair];
    assign addend  = yop[bitcnt] ? ({{WIDTH{1'b0}}, xop} << bitcnt) : '0;
    assign acc_sum = {1'b0, acc} + {1'b0, product};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= LOAD;
            count        <= '0;
            pair         <= '0;
            bitcnt       <= '0;
            product      <= '0;
            acc          <= '0;
            carry        <= 1'b0;
            xs           <= '{default: '0};
            ys           <= '{default: '0};
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.overflow <= 1'b0;
        end else if (bus.clear) begin
            state        <= LOAD;
            count        <= '0;
            pair         <= '0;
            bitcnt       <= '0;
            product      <= '0;
            acc          <= '0;
            carry        <= 1'b0;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        // Slot layout x0,y0,x1,y1...: count[0] picks x/y, upper bits pick the pair.
                        if (count[0])
                            ys[count[CW-1:1]] <= bus.in_data;
                        else
                            xs[count[CW-1:1]] <= bus.in_data;
                        if (count == CW'(2 * NPAIRS - 1)) begin
                            count        <= '0;
                            pair         <= '0;
                            bitcnt       <= '0;
                            product      <= '0;
                            acc          <= '0;
                            carry        <= 1'b0;
                            bus.in_ready <= 1'b0;
                            bus.busy     <= 1'b1;
                            state        <= MUL;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                MUL: begin
                    product <= product + addend;
                    if (bitcnt == BW'(WIDTH - 1))
                        state <= ACC;
                    else
                        bitcnt <= bitcnt + 1'b1;
                end
                ACC: begin
                    acc   <= acc_sum[RW-1:0];
                    carry <= carry | acc_sum[RW];
                    if (pair == PW'(NPAIRS - 1)) begin
                        bus.busy <= 1'b0;
                        state    <= DONE;
                    end else begin
                        pair    <= pair + 1'b1;
                        bitcnt  <= '0;
                        product <= '0;
                        state   <= MUL;
                    end
                end
                DONE: begin
                    bus.done     <= 1'b1;
                    bus.overflow <= carry;
`ifdef MAC_SEQUENCER_SATURATE_EN
                    bus.result   <= carry ? '1 : acc;
`else
                    bus.result   <= acc;
`endif
                    bus.in_ready <= 1'b1;
                    state        <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer against a plain-arithmetic sum-of-products model.
module tb_mac_sequencer;
    localparam int WIDTH  = 8;
    localparam int NPAIRS = 2;
    localparam int NOPS   = 2 * NPAIRS;
    localparam int RW     = 2 * WIDTH;
    localparam int LAT    = NPAIRS * (WIDTH + 1) + 1;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    mac_sequencer_if #(.WIDTH(WIDTH)) bus ();

    mac_sequencer #(.WIDTH(WIDTH), .NPAIRS(NPAIRS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected result: running sum of products, carry flagged whenever a step crosses 2^RW.
    function automatic void model(input int unsigned ops [NOPS],
                                  output logic [RW-1:0] r, output logic o);
        longint a;
        longint lim;
        a   = 0;
        lim = longint'(1) << RW;
        o   = 1'b0;
        for (int i = 0; i < NPAIRS; i++) begin
            a = a + longint'(ops[2*i]) * longint'(ops[2*i+1]);
            if (a >= lim) begin
                o = 1'b1;
                a = a - lim;
            end
        end
        r = RW'(a);
`ifdef MAC_SEQUENCER_SATURATE_EN
        if (o) r = '1;
`endif
    endfunction

    task automatic feed_batch(input int unsigned ops [NOPS]);
        for (int i = 0; i < NOPS; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = WIDTH'(ops[i]);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Called at the first negedge after the final accept; lat counts negedges until done.
    task automatic wait_done(output int lat, output int busy_cyc, output bit held);
        logic [RW-1:0] r0;
        r0       = bus.result;
        lat      = -1;
        busy_cyc = 0;
        held     = 1'b1;
        for (int k = 0; k <= 60; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.result !== r0) held = 1'b0;
        end
    endtask

    task automatic test_reset;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passed++;
        total++; if (bus.result !== '0) $display("FAIL reset_result got %h want 0", bus.result); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", bus.overflow); else passed++;
    endtask

    task automatic test_basic;
        int unsigned ops [NOPS];
        logic [RW-1:0] er;
        logic eo;
        int lat, bc;
        bit held;
        ops = '{3, 5, 7, 11};
        model(ops, er, eo);
        feed_batch(ops);
        total++; if (bus.in_ready !== 1'b0) $display("FAIL basic_ready_drop got %b want 0", bus.in_ready); else passed++;
        wait_done(lat, bc, held);
        total++; if (lat != LAT) $display("FAIL basic_latency got %0d want %0d", lat, LAT); else passed++;
        total++; if (bc != LAT - 1) $display("FAIL basic_busy_cycles got %0d want %0d", bc, LAT - 1); else passed++;
        total++; if (bus.result !== er) $display("FAIL basic_result got %h want %h", bus.result, er); else passed++;
        total++; if (bus.overflow !== eo) $display("FAIL basic_overflow got %b want %b", bus.overflow, eo); else passed++;
        @(negedge clk);
        total++; if (bus.done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", bus.done); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL basic_ready_back got %b want 1", bus.in_ready); else passed++;
    endtask

    task automatic test_overflow;
        int unsigned ops [NOPS];
        logic [RW-1:0] er;
        logic eo;
        int lat, bc;
        bit held;
        ops = '{255, 255, 255, 255};
        model(ops, er, eo);
        feed_batch(ops);
        wait_done(lat, bc, held);
        total++; if (lat != LAT) $display("FAIL ovf_latency got %0d want %0d", lat, LAT); else passed++;
        total++; if (bus.result !== er) $display("FAIL ovf_result got %h want %h", bus.result, er); else passed++;
        total++; if (bus.overflow !== eo) $display("FAIL ovf_flag got %b want %b", bus.overflow, eo); else passed++;
    endtask

    task automatic test_ignore_busy;
        int unsigned ops [NOPS];
        logic [RW-1:0] er;
        logic eo;
        int lat, bc;
        bit held;
        ops = '{2, 3, 0, 0};
        model(ops, er, eo);
        feed_batch(ops);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        wait_done(lat, bc, held);
        bus.in_valid = 1'b0;
        total++; if (held !== 1'b1) $display("FAIL busy_hold_result got %b want 1", held); else passed++;
        total++; if (lat != LAT) $display("FAIL busy_latency got %0d want %0d", lat, LAT); else passed++;
        total++; if (bus.result !== er) $display("FAIL busy_result got %h want %h", bus.result, er); else passed++;
        total++; if (bus.overflow !== eo) $display("FAIL busy_overflow got %b want %b", bus.overflow, eo); else passed++;
    endtask

    task automatic test_reset_mid;
        int unsigned ops [NOPS];
        logic [RW-1:0] er;
        logic eo;
        int lat, bc;
        bit held;
        bit saw_done;
        ops = '{1, 2, 3, 4};
        feed_batch(ops);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (bus.result !== '0) $display("FAIL midrst_result got %h want 0", bus.result); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_ready got %b want 1", bus.in_ready); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", bus.busy); else passed++;
        @(negedge clk);
        reset = 1'b1;
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) $display("FAIL midrst_no_done got %b want 0", saw_done); else passed++;
        ops = '{1, 1, 1, 1};
        model(ops, er, eo);
        feed_batch(ops);
        wait_done(lat, bc, held);
        total++; if (bus.result !== er) $display("FAIL midrst_fresh_result got %h want %h", bus.result, er); else passed++;
    endtask

    task automatic test_clear;
        int unsigned ops [NOPS];
        logic [RW-1:0] er;
        logic eo;
        int lat, bc;
        bit held;
        @(negedge clk); bus.in_valid = 1'b1; bus.in_data = 8'd7;
        @(negedge clk); bus.in_valid = 1'b1; bus.in_data = 8'd8;
        @(negedge clk); bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h09;
        @(negedge clk); bus.clear = 1'b0; bus.in_valid = 1'b0;
        total++; if (bus.result !== '0) $display("FAIL clear_result got %h want 0", bus.result); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL clear_done got %b want 0", bus.done); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL clear_ready got %b want 1", bus.in_ready); else passed++;
        ops = '{4, 4, 2, 2};
        model(ops, er, eo);
        feed_batch(ops);
        wait_done(lat, bc, held);
        total++; if (lat != LAT) $display("FAIL clear_next_latency got %0d want %0d", lat, LAT); else passed++;
        total++; if (bus.result !== er) $display("FAIL clear_next_result got %h want %h", bus.result, er); else passed++;
    endtask

    task automatic test_zero;
        int unsigned ops [NOPS];
        int lat, bc;
        bit held;
        ops = '{0, 0, 0, 0};
        feed_batch(ops);
        wait_done(lat, bc, held);
        total++; if (lat != LAT) $display("FAIL zero_latency got %0d want %0d", lat, LAT); else passed++;
        total++; if (bus.result !== '0) $display("FAIL zero_result got %h want 0", bus.result); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("FAIL zero_overflow got %b want 0", bus.overflow); else passed++;
    endtask

    task automatic test_random;
        int unsigned ops [NOPS];
        logic [RW-1:0] er;
        logic eo;
        int lat, bc;
        bit held;
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < NOPS; i++)
                ops[i] = (n % 3 == 0) ? $urandom_range(255, 200) : $urandom_range(255, 0);
            model(ops, er, eo);
            feed_batch(ops);
            wait_done(lat, bc, held);
            total++; if (lat != LAT) $display("FAIL rand%0d_latency got %0d want %0d", n, lat, LAT); else passed++;
            total++; if (bus.result !== er) $display("FAIL rand%0d_result got %h want %h", n, bus.result, er); else passed++;
            total++; if (bus.overflow !== eo) $display("FAIL rand%0d_overflow got %b want %b", n, bus.overflow, eo); else passed++;
        end
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        reset        = 1'b1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #1 reset = 1'b0;
        #1 test_reset;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        test_basic;
        test_overflow;
        test_ignore_busy;
        test_reset_mid;
        test_clear;
        test_zero;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
